approx_mult_accum: RTL and testbench

- Downstream consumer of the 8x8 approximate multipliers.
- Takes a stream of 16-bit unsigned products, sums a programmable number of them into a wide accumulator, and returns the sum through a valid/ready handshake.
- Used for dot-product and error-statistics runs over approximate multiplier outputs, with optional saturation and a sticky overflow flag.

---
 rtl/approx_mult_accum.sv | 139 +++++++++++++
 tb/tb_approx_mult_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_accum.sv
// approx_mult_accum: sums a programmable run of 16-bit products into a
// wide accumulator and hands the result out over a valid/ready handshake.
module approx_mult_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [LEN_W-1:0] count;
  logic             ovf;
  logic             beat;
  logic             last;
  logic [ACC_W:0]   sum;

  assign beat = prod_valid & prod_ready;
  assign last = (count == LEN_W'(1));

  // one extra bit so the carry-out flags an overflowing add
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

  // saturate or wrap the sum depending on the build option
  always_comb begin
    acc_nx = sum[ACC_W-1:0];
    if (sum[ACC_W] && SAT) begin
      acc_nx = '1;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat && last) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // handshake and status outputs are pure functions of state
  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
      end
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      HOLD: begin
        acc_valid  = 1'b1;
        busy       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // accumulator, beat counter and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= len;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc_nx;
            count <= count - LEN_W'(1);
            if (sum[ACC_W]) begin
              ovf <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf;

endmodule

// File: tb/tb_approx_mult_accum.sv
// tb_approx_mult_accum: directed checks of the accumulator, one task per
// scenario; two 16-bit instances cover saturate and wrap side by side.
module tb_approx_mult_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] prod;
  logic        prod_valid;
  logic        acc_ready;

  logic        pr, av, ov, bz;
  logic [23:0] ao;
  logic        s_pr, s_av, s_ov, s_bz;
  logic [15:0] s_ao;
  logic        w_pr, w_av, w_ov, w_bz;
  logic [15:0] w_ao;

  int n_cmp;
  int n_err;

  approx_mult_accum u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(pr),
    .acc_out(ao), .acc_valid(av), .acc_ready(acc_ready),
    .overflow(ov), .busy(bz)
  );

  approx_mult_accum #(.ACC_W(16), .LEN_W(8), .SAT(1'b1)) u_s16 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(s_pr),
    .acc_out(s_ao), .acc_valid(s_av), .acc_ready(acc_ready),
    .overflow(s_ov), .busy(s_bz)
  );

  approx_mult_accum #(.ACC_W(16), .LEN_W(8), .SAT(1'b0)) u_w16 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(w_pr),
    .acc_out(w_ao), .acc_valid(w_av), .acc_ready(acc_ready),
    .overflow(w_ov), .busy(w_bz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; len = 0; prod = 0;
    prod_valid = 0; acc_ready = 0;
    #2;
    n_cmp++; if (ao !== 24'h0) begin n_err++; $display("FAIL rst_acc_out got %h exp 000000", ao); end
    n_cmp++; if ({pr, av, ov, bz} !== 4'b0000) begin n_err++; $display("FAIL rst_flags got %b exp 0000", {pr, av, ov, bz}); end
    n_cmp++; if ({s_pr, s_av, s_ov, s_bz, s_ao} !== 20'h0) begin n_err++; $display("FAIL rst_s16 got %h exp 00000", {s_pr, s_av, s_ov, s_bz, s_ao}); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bz !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got %b exp 0", bz); end
  endtask

  task automatic test_basic();
    logic [15:0] vals [3];
    vals[0] = 16'h0010; vals[1] = 16'h0020; vals[2] = 16'h0030;
    acc_ready = 1'b1;
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    n_cmp++; if ({pr, bz, av} !== 3'b110) begin n_err++; $display("FAIL basic_accum_flags got %b exp 110", {pr, bz, av}); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (av !== 1'b0) begin n_err++; $display("FAIL basic_early_valid beat %0d got %b exp 0", i, av); end
      prod = vals[i]; prod_valid = 1'b1;
      tick();
    end
    prod_valid = 1'b0;
    n_cmp++; if (av !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", av); end
    n_cmp++; if (ao !== 24'h000060) begin n_err++; $display("FAIL basic_sum got %h exp 000060", ao); end
    n_cmp++; if ({ov, pr} !== 2'b00) begin n_err++; $display("FAIL basic_ovf_ready got %b exp 00", {ov, pr}); end
    tick();
    n_cmp++; if ({av, bz} !== 2'b00) begin n_err++; $display("FAIL basic_back_idle got %b exp 00", {av, bz}); end
    n_cmp++; if (ao !== 24'h000060) begin n_err++; $display("FAIL basic_idle_hold got %h exp 000060", ao); end
  endtask

  task automatic test_gaps_hold();
    acc_ready = 1'b0;
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    len = 8'd1;
    prod = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      prod_valid = ((i % 2) == 0);
      tick();
      if (i < 6) begin
        n_cmp++; if ({av, bz} !== 2'b01) begin n_err++; $display("FAIL gaps_state cyc %0d got %b exp 01", i, {av, bz}); end
      end
    end
    prod_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({av, pr, bz} !== 3'b101) begin n_err++; $display("FAIL hold_flags cyc %0d got %b exp 101", k, {av, pr, bz}); end
      n_cmp++; if (ao !== 24'h03FFFC) begin n_err++; $display("FAIL hold_sum cyc %0d got %h exp 03fffc", k, ao); end
      tick();
    end
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL hold_ovf got %b exp 0", ov); end
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    n_cmp++; if ({av, bz} !== 2'b00) begin n_err++; $display("FAIL hold_release got %b exp 00", {av, bz}); end
  endtask

  task automatic run(input logic [7:0] n, input logic [15:0] p0,
                     input logic [15:0] p1, input logic [15:0] p2);
    logic [15:0] v [3];
    v[0] = p0; v[1] = p1; v[2] = p2;
    acc_ready = 1'b1;
    start = 1'b1; len = n;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      prod = v[i]; prod_valid = 1'b1;
      tick();
    end
    prod_valid = 1'b0;
  endtask

  task automatic test_overflow();
    run(8'd2, 16'hFFFF, 16'h0002, 16'h0);
    n_cmp++; if ({s_av, s_ao, s_ov} !== {1'b1, 16'hFFFF, 1'b1}) begin n_err++; $display("FAIL sat16 got v%b %h o%b exp v1 ffff o1", s_av, s_ao, s_ov); end
    n_cmp++; if ({w_av, w_ao, w_ov} !== {1'b1, 16'h0001, 1'b1}) begin n_err++; $display("FAIL wrap16 got v%b %h o%b exp v1 0001 o1", w_av, w_ao, w_ov); end
    n_cmp++; if ({ao, ov} !== {24'h010001, 1'b0}) begin n_err++; $display("FAIL wide24 got %h o%b exp 010001 o0", ao, ov); end
    tick();
    run(8'd3, 16'hFFFF, 16'h0002, 16'h0001);
    n_cmp++; if ({s_ao, s_ov} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL sat16_stick got %h o%b exp ffff o1", s_ao, s_ov); end
    n_cmp++; if ({w_ao, w_ov} !== {16'h0002, 1'b1}) begin n_err++; $display("FAIL wrap16_cont got %h o%b exp 0002 o1", w_ao, w_ov); end
    tick();
    run(8'd1, 16'h0005, 16'h0, 16'h0);
    n_cmp++; if ({s_ao, s_ov, w_ao, w_ov} !== {16'h0005, 1'b0, 16'h0005, 1'b0}) begin n_err++; $display("FAIL ovf_clear got %h %b %h %b exp 0005 0 0005 0", s_ao, s_ov, w_ao, w_ov); end
    tick();
  endtask

  task automatic test_zero_len();
    acc_ready = 1'b0;
    prod = 16'h1234; prod_valid = 1'b1;
    start = 1'b1; len = 8'd0;
    tick();
    n_cmp++; if ({av, pr, bz} !== 3'b101) begin n_err++; $display("FAIL zero_flags got %b exp 101", {av, pr, bz}); end
    n_cmp++; if (ao !== 24'h0) begin n_err++; $display("FAIL zero_sum got %h exp 000000", ao); end
    len = 8'd2;
    tick();
    n_cmp++; if ({av, bz, ao} !== {2'b11, 24'h0}) begin n_err++; $display("FAIL zero_restart got %b %h exp 11 000000", {av, bz}, ao); end
    acc_ready = 1'b1;
    tick();
    start = 1'b0; prod_valid = 1'b0;
    n_cmp++; if ({av, bz} !== 2'b00) begin n_err++; $display("FAIL zero_ack_start got %b exp 00", {av, bz}); end
    tick();
    n_cmp++; if (bz !== 1'b0) begin n_err++; $display("FAIL zero_stay_idle got %b exp 0", bz); end
  endtask

  task automatic test_abort();
    acc_ready = 1'b1;
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    prod = 16'h0100; prod_valid = 1'b1;
    tick();
    tick();
    prod_valid = 1'b0;
    n_cmp++; if ({bz, ao} !== {1'b1, 24'h000200}) begin n_err++; $display("FAIL abort_partial got %b %h exp 1 000200", bz, ao); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({ao, pr, av, ov, bz} !== 28'h0) begin n_err++; $display("FAIL abort_async got %h exp 0000000", {ao, pr, av, ov, bz}); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if ({av, bz} !== 2'b00) begin n_err++; $display("FAIL abort_idle got %b exp 00", {av, bz}); end
    run(8'd1, 16'h0007, 16'h0, 16'h0);
    n_cmp++; if ({av, ao} !== {1'b1, 24'h000007}) begin n_err++; $display("FAIL abort_rerun got %b %h exp 1 000007", av, ao); end
    tick();
  endtask

  task automatic test_back_to_back();
    run(8'd2, 16'h0001, 16'h0002, 16'h0);
    n_cmp++; if ({av, ao} !== {1'b1, 24'h000003}) begin n_err++; $display("FAIL b2b_a got %b %h exp 1 000003", av, ao); end
    tick();
    run(8'd2, 16'h1000, 16'h2000, 16'h0);
    n_cmp++; if ({av, ao} !== {1'b1, 24'h003000}) begin n_err++; $display("FAIL b2b_b got %b %h exp 1 003000", av, ao); end
    tick();
    n_cmp++; if ({av, bz} !== 2'b00) begin n_err++; $display("FAIL b2b_end got %b exp 00", {av, bz}); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_gaps_hold();
    test_overflow();
    test_zero_len();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
